// File: rtl/tt_um_cla8_if.sv
// tt_um_cla8_if -- TinyTapeout tile pin bundle for the 8-bit CLA adder.
//
// Signals:
//   ena      tile selected (ignored by the adder)
//   ui_in    operand A (dedicated inputs)
//   uio_in   operand B (bidirectional pins used as inputs)
//   uo_out   8-bit sum
//   uio_out  bidirectional output data, always 8'h00
//   uio_oe   bidirectional output enables, always 8'h00
//
// Modports:
//   master  the side that drives operands (harness / testbench)
//   slave   the adder tile itself
interface tt_um_cla8_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_cla8.sv
// tt_um_cla8 -- 8-bit carry-lookahead adder as a TinyTapeout user tile.
//
// Structure: bitwise generate/propagate, two 4-bit lookahead groups and a
// group-level carry unit, so no carry ever ripples from bit to bit.
//
// Ports:
//   clk    clock (only used when CLA8_REG_OUT_EN is defined)
//   rst_n  asynchronous active-low reset (only used with CLA8_REG_OUT_EN)
//   bus    tt_um_cla8_if.slave: ui_in = A, uio_in = B, uo_out = (A+B) mod 256,
//          uio_out and uio_oe tied to 8'h00, ena ignored
//
// Configuration macro:
//   CLA8_REG_OUT_EN  when defined, the sum is registered (1-cycle latency,
//                    cleared asynchronously by rst_n); when undefined the
//                    output is purely combinational and no flops exist.
module tt_um_cla8 (
  input  logic           clk,
  input  logic           rst_n,
  tt_um_cla8_if.slave    bus
);

  // 4-bit lookahead group. Returns {G, P, c3, c2, c1}; every carry is a flat
  // sum-of-products of the group inputs and the group carry-in.
  function automatic logic [4:0] group_la(input logic [3:0] g,
                                          input logic [3:0] p,
                                          input logic       cin);
    logic c1, c2, c3, grp_g, grp_p;
    c1    = g[0] | (p[0] & cin);
    c2    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
    return {grp_g, grp_p, c3, c2, c1};
  endfunction

  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;
  logic [4:0] grp0;
  logic [4:0] grp1;
  logic       c0;
  logic       c4;
  logic       c8;
  logic [7:0] sum;

  assign c0 = 1'b0;
  assign g  = bus.ui_in & bus.uio_in;
  assign p  = bus.ui_in ^ bus.uio_in;

  assign grp0 = group_la(g[3:0], p[3:0], c0);

  // Group carry unit: both group carries come straight from G/P terms and c0,
  // so the upper group never waits on the lower group's internal carries.
  assign c4 = grp0[4] | (grp0[3] & c0);
  assign grp1 = group_la(g[7:4], p[7:4], c4);
  assign c8 = grp1[4] | (grp1[3] & grp0[4]) | (grp1[3] & grp0[3] & c0);

  assign c   = {grp1[2:0], c4, grp0[2:0], c0};
  assign sum = p ^ c;

  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

`ifdef CLA8_REG_OUT_EN
  logic [7:0] sum_q;

  // Output register; reset discards whatever sum was about to be presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum_q <= 8'h00;
    else
      sum_q <= sum;
  end

  assign bus.uo_out = sum_q;

  // Carry-out and ena have no pin to drive.
  logic unused_sig;
  assign unused_sig = &{1'b0, bus.ena, c8};
`else
  assign bus.uo_out = sum;

  // Combinational build: clock, reset, ena and carry-out are deliberately unused.
  logic unused_sig;
  assign unused_sig = &{1'b0, clk, rst_n, bus.ena, c8};
`endif

endmodule

// File: tb/tb_tt_um_cla8.sv
// tb_tt_um_cla8 -- self-checking bench for tt_um_cla8.
//
// Drives directed operand pairs with hand-computed sums, then every A/B pair.
// Works for both builds; with CLA8_REG_OUT_EN defined, every sum is checked
// one clock after its operands are applied, and reset behaviour is exercised.
module tb_tt_um_cla8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  tt_um_cla8_if bus();

  tt_um_cla8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the expected one and log mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one operand pair and wait until the sum should be visible.
  // Called 1 time unit after a rising edge, so inputs settle well before
  // the next edge in the registered build.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    bus.ui_in  = a;
    bus.uio_in = b;
`ifdef CLA8_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  logic [7:0] vec_a   [6] = '{8'h00, 8'h0F, 8'hFF, 8'h80, 8'h5A, 8'hC8};
  logic [7:0] vec_b   [6] = '{8'h00, 8'h01, 8'h01, 8'h80, 8'hA5, 8'h37};
  logic [7:0] vec_sum [6] = '{8'h00, 8'h10, 8'h00, 8'h00, 8'hFF, 8'hFF};

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h12;
    bus.uio_in = 8'h34;

    // Hold reset with operands 0x12/0x34 across a couple of edges.
    repeat (2) @(posedge clk);
    #1;
`ifdef CLA8_REG_OUT_EN
    checkOutput("rst_hold", bus.uo_out, 8'h00);
`else
    checkOutput("comb_in_reset", bus.uo_out, 8'h46);
`endif
    checkOutput("rst_uio_oe", bus.uio_oe, 8'h00);
    checkOutput("rst_uio_out", bus.uio_out, 8'h00);

    // Release reset between edges; first capture at the next rising edge.
    rst_n = 1'b1;
`ifdef CLA8_REG_OUT_EN
    checkOutput("pre_first_edge", bus.uo_out, 8'h00);
`endif
    applyStimulus(8'h12, 8'h34);
    checkOutput("first_capture", bus.uo_out, 8'h46);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vec_a[i], vec_b[i]);
      checkOutput($sformatf("vec%0d", i), bus.uo_out, vec_sum[i]);
    end
    checkOutput("uio_oe", bus.uio_oe, 8'h00);
    checkOutput("uio_out", bus.uio_out, 8'h00);

    // Every operand pair, one new pair per step.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        logic [7:0] exp_sum;
        exp_sum = 8'((a + b) % 256);
        applyStimulus(8'(a), 8'(b));
        checkOutput("sweep", bus.uo_out, exp_sum);
      end
    end

    // Drop reset between edges with new operands pending.
    bus.ui_in  = 8'h12;
    bus.uio_in = 8'h34;
    #2;
    rst_n = 1'b0;
    #1;
`ifdef CLA8_REG_OUT_EN
    checkOutput("async_clear", bus.uo_out, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("pending_discarded", bus.uo_out, 8'h00);
    rst_n = 1'b1;
    applyStimulus(8'h12, 8'h34);
    checkOutput("after_rerelease", bus.uo_out, 8'h46);
`else
    checkOutput("comb_rst_no_effect", bus.uo_out, 8'h46);
    rst_n = 1'b1;
    applyStimulus(8'h0F, 8'h01);
    checkOutput("comb_after_rst", bus.uo_out, 8'h10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
